seg_scan4: RTL and testbench
============================

SEG_SCAN4 -- requirements
Module: seg_scan4

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 17, the prescaler width in bits; one digit slot lasts 2^SCAN_DIV clk cycles.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port load, input, 1, a capture strobe sampled on every clk edge.
REQ-005 SHALL have port hex, input, 16, the display value; nibble i drives digit i, and digit 0 is rightmost.
REQ-006 SHALL have port pt, input, 4; pt[i]=1 lights the decimal point of digit i.
REQ-007 SHALL have port en, input, 4; en[i]=1 enables digit i.
REQ-008 SHALL have port SEGMENT, output, 8, active-low; [7]=dp and [6:0]=g..a.
REQ-009 SHALL have port AN, output, 4, active-low digit anodes.
REQ-010 SHALL have port frame, output, 1, a 1-cycle pulse at each scan wrap.

Function
REQ-011 SHALL capture hex, pt and en into shadow registers on the edge where load=1; shadows hold while load=0.
REQ-012 SHALL drive the display only from the shadow registers, never from the live inputs.
REQ-013 SHALL run the prescaler cnt (SCAN_DIV bits) by incrementing it every cycle, wrapping from all-ones to 0.
REQ-014 SHALL raise tick when cnt is all-ones.
REQ-015 SHALL run a 2-bit digit index idx that advances on tick and wraps from 3 to 0.
REQ-016 SHALL pulse frame high for exactly one cycle, on the cycle after idx changes from 3 to 0.
REQ-017 SHALL register AN and SEGMENT, each updated 1 cycle after a change in idx or in the shadow registers.
REQ-018 SHALL drive AN = ~(onehot(idx) & en_shadow), so at most one AN bit is low at a time.
REQ-019 SHALL drive SEGMENT[7] = ~pt_shadow[idx].
REQ-020 SHALL drive SEGMENT[6:0] from nibble idx using this table (hex values): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-021 SHALL force SEGMENT=8'hFF for a digit whose en_shadow bit is 0.
REQ-022 SHALL, when load and tick occur in the same cycle, apply both; the next registered output uses the new idx and the new shadow data.
REQ-023 SHALL leave cnt and idx unaffected by load; capturing new data never restarts the scan.

Reset
REQ-024 SHALL, on rst=1 at a clk edge, set cnt=0, idx=0, all shadows=0, AN=4'hF, SEGMENT=8'hFF and frame=0.
REQ-025 SHALL, when rst is asserted mid-scan, abandon the scan and restart at digit 0 with a full slot once rst deasserts.
REQ-026 SHALL give rst priority over load.

Configuration
REQ-027 SHALL, with SEG_ZERO_BLANK_EN defined, blank digit i for i>0 (AN bit high, SEGMENT=8'hFF) when hex_shadow nibbles i..3 are all 0; digit 0 is never blanked by this rule.
REQ-028 SHALL, without SEG_ZERO_BLANK_EN, display leading zeros normally, with gating only by en_shadow.
REQ-029 SHALL evaluate zero-blanking on shadows only, with the same 1-cycle output latency.

Verification
REQ-030 SHALL cover reset: with SCAN_DIV=2, hold rst for 3 cycles -> AN=F, SEGMENT=FF, frame=0; 1 cycle after load of hex=1234, en=F, pt=0 -> AN=E, SEGMENT=99 (digit 0 shows "4").
REQ-031 SHALL cover a full scan: after that load, AN steps E, D, B, 7 every 4 cycles with SEGMENT 99, B0, A4, F9; frame pulses once per 16 cycles.
REQ-032 SHALL cover enables and points: load hex=00A0, en=5, pt=2 -> digit slot 1 shows AN=F, SEGMENT=FF (disabled), and digit slot 0 shows AN=E, SEGMENT=C0.
REQ-033 SHALL cover input isolation: change hex with load=0 -> no output change; load together with tick -> new data appears on the next digit 1 cycle later, and scan timing is unchanged.
REQ-034 SHALL cover reset mid-scan: assert rst while idx=2 -> AN=F the next cycle; after release, digit 0 is displayed for 4 cycles first.
REQ-035 SHALL cover SEG_ZERO_BLANK_EN: load hex=0007, en=F -> only AN=E is ever low, with SEGMENT=F8; without the macro, digits 1..3 show C0.

Source files
------------

// File: rtl/seg_scan4.sv
// Four-digit multiplexed seven-segment scanner with load-strobed shadow registers.
// Optional macro SEG_ZERO_BLANK_EN blanks leading-zero digits (digit 0 always shown).
module seg_scan4 #(
   parameter int SCAN_DIV = 17
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] hex,
   input  logic [3:0]  pt,
   input  logic [3:0]  en,
   output logic [7:0]  SEGMENT,
   output logic [3:0]  AN,
   output logic        frame
);

   logic [SCAN_DIV-1:0] cnt;
   logic                tick;
   logic [1:0]          idx;
   logic [15:0]         hex_sh;
   logic [3:0]          pt_sh;
   logic [3:0]          en_sh;
   logic [3:0]          blank;
   logic [3:0]          nibble;
   logic [6:0]          seg7;
   logic                dig_on;
   logic [3:0]          an_nxt;
   logic [7:0]          seg_nxt;

   assign tick = (cnt == {SCAN_DIV{1'b1}});

   // Scan timing runs independently of load; only rst restarts it.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         idx    <= 2'd0;
         hex_sh <= 16'h0000;
         pt_sh  <= 4'h0;
         en_sh  <= 4'h0;
      end else begin
         cnt <= cnt + 1'b1;
         if (tick) idx <= idx + 2'd1;
         if (load) begin
            hex_sh <= hex;
            pt_sh  <= pt;
            en_sh  <= en;
         end
      end
   end

`ifdef SEG_ZERO_BLANK_EN
   always_comb begin
      blank    = 4'b0000;
      blank[1] = (hex_sh[15:4] == 12'h000);
      blank[2] = (hex_sh[15:8] == 8'h00);
      blank[3] = (hex_sh[15:12] == 4'h0);
   end
`else
   assign blank = 4'b0000;
`endif

   assign nibble = hex_sh[{idx, 2'b00} +: 4];

   always_comb begin
      seg7 = 7'h7F;
      case (nibble)
         4'h0: seg7 = 7'h40;
         4'h1: seg7 = 7'h79;
         4'h2: seg7 = 7'h24;
         4'h3: seg7 = 7'h30;
         4'h4: seg7 = 7'h19;
         4'h5: seg7 = 7'h12;
         4'h6: seg7 = 7'h02;
         4'h7: seg7 = 7'h78;
         4'h8: seg7 = 7'h00;
         4'h9: seg7 = 7'h10;
         4'hA: seg7 = 7'h08;
         4'hB: seg7 = 7'h03;
         4'hC: seg7 = 7'h46;
         4'hD: seg7 = 7'h21;
         4'hE: seg7 = 7'h06;
         4'hF: seg7 = 7'h0E;
         default: seg7 = 7'h7F;
      endcase
   end

   always_comb begin
      dig_on  = en_sh[idx] & ~blank[idx];
      an_nxt  = 4'hF;
      seg_nxt = 8'hFF;
      if (dig_on) begin
         an_nxt  = ~(4'b0001 << idx);
         seg_nxt = {~pt_sh[idx], seg7};
      end
   end

   // Outputs lag idx/shadow changes by exactly one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         AN      <= 4'hF;
         SEGMENT <= 8'hFF;
         frame   <= 1'b0;
      end else begin
         AN      <= an_nxt;
         SEGMENT <= seg_nxt;
         frame   <= tick & (idx == 2'd3);
      end
   end

endmodule

// File: tb/tb_seg_scan4.sv
// Randomized scoreboard bench for seg_scan4 (SCAN_DIV=2) against a cycle-count based model.
// Define SEG_ZERO_BLANK_EN for both bench and RTL to exercise leading-zero blanking.
module tb_seg_scan4;

   localparam int SD   = 2;
   localparam int SLOT = 1 << SD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] hex = 16'h0;
   logic [3:0]  pt = 4'h0;
   logic [3:0]  en = 4'h0;
   logic [7:0]  SEGMENT;
   logic [3:0]  AN;
   logic        frame;

   int checks = 0;
   int errors = 0;

   logic [12:0] exp_q[$];

   // model state: cycles since the last reset edge, plus captured display data
   int          age = 0;
   logic [15:0] m_hex = 16'h0;
   logic [3:0]  m_pt = 4'h0;
   logic [3:0]  m_en = 4'h0;

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seg_scan4 #(.SCAN_DIV(SD)) dut (
      .clk(clk), .rst(rst), .load(load), .hex(hex), .pt(pt), .en(en),
      .SEGMENT(SEGMENT), .AN(AN), .frame(frame)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] disp(int d, logic [15:0] h, logic [3:0] p, logic [3:0] e);
      logic [3:0] nib;
      logic       on;
      logic [3:0] an;
      logic [7:0] seg;
      nib = 4'((h >> (4 * d)) & 16'hF);
      on  = e[d];
`ifdef SEG_ZERO_BLANK_EN
      if (d > 0 && (h >> (4 * d)) == 16'h0) on = 1'b0;
`endif
      an  = 4'hF;
      seg = 8'hFF;
      if (on) begin
         an[d] = 1'b0;
         seg   = {~p[d], seg_tab[nib]};
      end
      return {an, seg};
   endfunction

   function automatic int cur_idx();
      return (age / SLOT) % 4;
   endfunction

   // Drive one cycle of inputs and push the response expected right after the edge.
   task automatic step(input logic r, input logic l, input logic [15:0] h,
                       input logic [3:0] p, input logic [3:0] e);
      @(negedge clk);
      rst = r; load = l; hex = h; pt = p; en = e;
      if (r) begin
         exp_q.push_back({1'b0, 4'hF, 8'hFF});
         age = 0; m_hex = 16'h0; m_pt = 4'h0; m_en = 4'h0;
      end else begin
         exp_q.push_back({(age % (4 * SLOT)) == (4 * SLOT - 1),
                          disp(cur_idx(), m_hex, m_pt, m_en)});
         age = age + 1;
         if (l) begin m_hex = h; m_pt = p; m_en = e; end
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, hex, pt, en);
   endtask

   task automatic noise(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
   endtask

   // monitor: output is presented every cycle, compared after the edge settles
   always @(posedge clk) begin
      logic [12:0] e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks = checks + 1;
         if ({frame, AN, SEGMENT} !== e) begin
            errors = errors + 1;
            $display("FAIL out t=%0t: got frame=%b AN=%h SEGMENT=%h, expected frame=%b AN=%h SEGMENT=%h",
                     $time, frame, AN, SEGMENT, e[12], e[11:8], e[7:0]);
         end
      end
   end

   initial begin
      step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
      step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
      step(1'b1, 1'b1, 16'hFFFF, 4'hF, 4'hF);
      step(1'b0, 1'b1, 16'h1234, 4'h0, 4'hF);
      idle(40);
      step(1'b0, 1'b1, 16'h00A0, 4'h2, 4'h5);
      idle(20);
      noise(12);
      // load coinciding with the slot tick
      while ((age % SLOT) != SLOT - 1) step(1'b0, 1'b0, hex, pt, en);
      step(1'b0, 1'b1, 16'h5A3C, 4'h9, 4'hF);
      idle(20);
      // reset in the middle of digit 2
      while (cur_idx() != 2) step(1'b0, 1'b0, hex, pt, en);
      idle(1);
      step(1'b1, 1'b0, hex, pt, en);
      step(1'b0, 1'b1, 16'h8421, 4'h0, 4'hF);
      idle(20);
      step(1'b0, 1'b1, 16'h0007, 4'h0, 4'hF);
      idle(20);
      step(1'b0, 1'b1, 16'h0300, 4'h1, 4'hF);
      idle(20);
      for (int i = 0; i < 1500; i++) begin
         logic r, l;
         r = ($urandom_range(0, 99) == 0);
         l = ($urandom_range(0, 7) == 0);
         step(r, l, 16'($urandom), 4'($urandom), 4'($urandom));
      end
      idle(2);
      @(negedge clk);
      checks = checks + 1;
      if (exp_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
